stream_selftest_top: RTL and testbench

- Self-contained single-clock data-integrity block.
- An internal producer writes an incrementing word sequence into a synchronous FIFO. A throttled consumer drains the FIFO and checks the sequence.
- Status and counters are exposed as outputs. It is the top-level exerciser used for simulation and waveform inspection; there are no functional data inputs.

---
 rtl/stream_selftest_top.sv | 114 +++++++++++
 tb/tb_stream_selftest_top.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stream_selftest_top.sv
// stream_selftest_top
// Self-contained data-integrity exerciser. An internal producer pushes an
// incrementing word sequence into a synchronous FIFO while a throttled
// consumer drains it and checks that the words arrive in order.
//
// Ports:
//   clk_a      - sole clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   fifo_level - current FIFO occupancy (0 .. 2**AW)
//   fifo_full  - occupancy equals 2**AW
//   fifo_empty - occupancy equals 0
//   rd_valid   - rd_data carries a freshly read word this cycle
//   rd_data    - word most recently read from the FIFO
//   tx_count   - words written by the producer (wrapping)
//   rx_count   - words seen by the checker (wrapping)
//   err_count  - sequence mismatches seen by the checker (saturating)
//   pass       - no errors so far and at least one word received
module stream_selftest_top #(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter int RD_PERIOD = 3,
  parameter int CW        = 16
) (
  input  logic          clk_a,
  input  logic          rst,
  output logic [AW:0]   fifo_level,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] err_count,
  output logic          pass
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (RD_PERIOD > 2) ? $clog2(RD_PERIOD) : 1;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wr_word;
  logic [DW-1:0] expected;
  logic [PW-1:0] phase;
  logic          wr_en;
  logic          rd_en;

  // Pointers carry one extra wrap bit, so the plain difference is the
  // occupancy even after either pointer has wrapped around.
  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_level == (AW + 1)'(DEPTH));
  assign fifo_empty = (fifo_level == '0);

  // Producer writes whenever there is room; consumer only gets a chance
  // once every RD_PERIOD cycles, and an empty FIFO forfeits that chance.
  assign wr_en = !rst && !fifo_full;
  assign rd_en = !rst && (phase == PW'(RD_PERIOD - 1)) && !fifo_empty;

  assign pass = (err_count == '0) && (rx_count != '0);

  // Storage array has no reset; its contents are only ever observed through
  // the pointers, which do reset.
  always_ff @(posedge clk_a) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_word;
    end
  end

  // Pointer, producer, consumer and checker state. The checker looks at the
  // registered read word one cycle after the read, so rx_count lags the
  // read pointer by rd_valid.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_word   <= '0;
      expected  <= '0;
      phase     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      if (phase == PW'(RD_PERIOD - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end

      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        wr_word  <= wr_word + 1'b1;
        tx_count <= tx_count + 1'b1;
      end

      rd_valid <= rd_en;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end

      if (rd_valid) begin
        rx_count <= rx_count + 1'b1;
        expected <= expected + 1'b1;
        if ((rd_data != expected) && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_selftest_top.sv
// Testbench for stream_selftest_top: directed reset/fill/long-run/mid-run
// reset steps against the default instance, plus a RD_PERIOD=2 instance
// sharing clock and reset.
module tb_stream_selftest_top;

  logic        clk_a;
  logic        rst;

  logic [4:0]  fifo_level,  fifo_level2;
  logic        fifo_full,   fifo_full2;
  logic        fifo_empty,  fifo_empty2;
  logic        rd_valid,    rd_valid2;
  logic [7:0]  rd_data,     rd_data2;
  logic [15:0] tx_count,    tx_count2;
  logic [15:0] rx_count,    rx_count2;
  logic [15:0] err_count,   err_count2;
  logic        pass,        pass2;

  int check_count = 0;
  int error_count = 0;

  logic [7:0] exp_word;
  logic [7:0] exp_word2;
  logic [7:0] last_word;
  logic       wrap_seen;
  logic       got_full;

  stream_selftest_top dut (
    .clk_a(clk_a), .rst(rst),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
    .pass(pass)
  );

  stream_selftest_top #(.RD_PERIOD(2)) dut2 (
    .clk_a(clk_a), .rst(rst),
    .fifo_level(fifo_level2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
    .rd_valid(rd_valid2), .rd_data(rd_data2),
    .tx_count(tx_count2), .rx_count(rx_count2), .err_count(err_count2),
    .pass(pass2)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives rst for one rising edge, samples 1 time unit later, then tracks
  // the expected read sequence and checks the count/occupancy invariant.
  task automatic applyStimulus(input logic rst_value);
    rst = rst_value;
    @(posedge clk_a);
    #1;
    if (rst_value) begin
      exp_word  = 8'h00;
      exp_word2 = 8'h00;
    end else begin
      if (rd_valid) begin
        checkOutput("seq_word", {24'd0, rd_data}, {24'd0, exp_word});
        if (last_word == 8'hFF && rd_data == 8'h00) wrap_seen = 1'b1;
        last_word = rd_data;
        exp_word  = exp_word + 8'd1;
      end
      if (rd_valid2) begin
        checkOutput("seq_word_p2", {24'd0, rd_data2}, {24'd0, exp_word2});
        exp_word2 = exp_word2 + 8'd1;
      end
    end
    checkOutput("invariant", {16'd0, 16'(tx_count - rx_count)},
                {16'd0, 16'({11'd0, fifo_level} + {15'd0, rd_valid})});
    checkOutput("invariant_p2", {16'd0, 16'(tx_count2 - rx_count2)},
                {16'd0, 16'({11'd0, fifo_level2} + {15'd0, rd_valid2})});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_empty"},    {31'd0, fifo_empty}, 32'd1);
    checkOutput({tag, "_full"},     {31'd0, fifo_full},  32'd0);
    checkOutput({tag, "_level"},    {27'd0, fifo_level}, 32'd0);
    checkOutput({tag, "_tx"},       {16'd0, tx_count},   32'd0);
    checkOutput({tag, "_rx"},       {16'd0, rx_count},   32'd0);
    checkOutput({tag, "_err"},      {16'd0, err_count},  32'd0);
    checkOutput({tag, "_pass"},     {31'd0, pass},       32'd0);
    checkOutput({tag, "_rd_valid"}, {31'd0, rd_valid},   32'd0);
    checkOutput({tag, "_rd_data"},  {24'd0, rd_data},    32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    exp_word  = 8'h00;
    exp_word2 = 8'h00;
    last_word = 8'h00;
    wrap_seen = 1'b0;
    got_full  = 1'b0;

    // Reset held for five edges.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    checkResetState("reset");
    checkOutput("reset_level_p2", {27'd0, fifo_level2}, 32'd0);

    // Edge 1: first write, no read yet.
    applyStimulus(1'b0);
    checkOutput("e1_level", {27'd0, fifo_level}, 32'd1);
    checkOutput("e1_tx",    {16'd0, tx_count},   32'd1);
    checkOutput("e1_valid", {31'd0, rd_valid},   32'd0);

    // Edge 2: second write.
    applyStimulus(1'b0);
    checkOutput("e2_level", {27'd0, fifo_level}, 32'd2);

    // Edge 3: first read opportunity, read plus write keeps level at 2.
    applyStimulus(1'b0);
    checkOutput("e3_valid", {31'd0, rd_valid},   32'd1);
    checkOutput("e3_data",  {24'd0, rd_data},    32'h00);
    checkOutput("e3_level", {27'd0, fifo_level}, 32'd2);
    checkOutput("e3_rx",    {16'd0, rx_count},   32'd0);

    // Edge 4: checker has consumed the first word.
    applyStimulus(1'b0);
    checkOutput("e4_rx",    {16'd0, rx_count},   32'd1);
    checkOutput("e4_pass",  {31'd0, pass},       32'd1);
    checkOutput("e4_valid", {31'd0, rd_valid},   32'd0);
    checkOutput("e4_level", {27'd0, fifo_level}, 32'd3);

    // Fill: 22 writes, 7 reads -> 15; edge 23 -> full at 16.
    for (int e = 5; e <= 22; e++) applyStimulus(1'b0);
    checkOutput("e22_full",  {31'd0, fifo_full},  32'd0);
    checkOutput("e22_level", {27'd0, fifo_level}, 32'd15);
    applyStimulus(1'b0);
    checkOutput("e23_full",  {31'd0, fifo_full},  32'd1);
    checkOutput("e23_tx",    {16'd0, tx_count},   32'd23);
    checkOutput("e23_level", {27'd0, fifo_level}, 32'd16);

    // Edge 24: read while full, producer stalled.
    applyStimulus(1'b0);
    checkOutput("e24_level", {27'd0, fifo_level}, 32'd15);
    checkOutput("e24_tx",    {16'd0, tx_count},   32'd23);
    checkOutput("e24_full",  {31'd0, fifo_full},  32'd0);

    // RD_PERIOD=2 instance: 30 writes, 15 reads -> 15; edge 31 -> full.
    for (int e = 25; e <= 30; e++) applyStimulus(1'b0);
    checkOutput("p2_e30_full",  {31'd0, fifo_full2},  32'd0);
    checkOutput("p2_e30_level", {27'd0, fifo_level2}, 32'd15);
    applyStimulus(1'b0);
    checkOutput("p2_e31_full",  {31'd0, fifo_full2},  32'd1);
    checkOutput("p2_e31_tx",    {16'd0, tx_count2},   32'd31);

    // Long run to edge 1500: reads at every third edge, last counted read at 1497.
    for (int e = 32; e <= 1500; e++) applyStimulus(1'b0);
    checkOutput("long_rx",     {16'd0, rx_count},   32'd499);
    checkOutput("long_err",    {16'd0, err_count},  32'd0);
    checkOutput("long_pass",   {31'd0, pass},       32'd1);
    checkOutput("long_wrap",   {31'd0, wrap_seen},  32'd1);
    checkOutput("long_p2_err", {16'd0, err_count2}, 32'd0);
    checkOutput("long_p2_rx",  {16'd0, rx_count2},  32'd749);

    // Mid-run reset while full, with a bounded wait for the full state.
    for (int i = 0; i < 10 && !got_full; i++) begin
      if (fifo_full) got_full = 1'b1;
      else applyStimulus(1'b0);
    end
    if (fifo_full) got_full = 1'b1;
    checkOutput("wait_full", {31'd0, got_full}, 32'd1);
    applyStimulus(1'b1);
    checkResetState("midrst");

    applyStimulus(1'b0);
    checkOutput("mr1_level", {27'd0, fifo_level}, 32'd1);
    checkOutput("mr1_tx",    {16'd0, tx_count},   32'd1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("mr3_valid", {31'd0, rd_valid}, 32'd1);
    checkOutput("mr3_data",  {24'd0, rd_data},  32'h00);
    applyStimulus(1'b0);
    checkOutput("mr4_rx",   {16'd0, rx_count}, 32'd1);
    checkOutput("mr4_pass", {31'd0, pass},     32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
